pid_ctrl_param: RTL and testbench

Parametrised PID position controller, successor to the fixed-width 100 kHz/10 kHz controller. Sampling uses a clock-enable tick from an internal prescaler; no derived clock is generated. Adds a fixed-latency pipeline with an output-valid strobe, run-time output and integrator limits, deadband, conditional-integration anti-windup and integrator clear. Sits between the encoder position counter and the PWM/H-bridge driver, with gains and limits written over AXI.

---
 rtl/pid_ctrl_param.sv | 175 +++++++++++++++++
 tb/tb_pid_ctrl_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl_param.sv
// Pipelined PID position controller: prescaled sample tick, 4-stage datapath, limits, deadband, anti-windup.
// Build option PID_DERIV_ON_MEAS_EN: derivative taken on measured position instead of error.
module pid_ctrl_param #(
  parameter int DATA_W     = 32,
  parameter int GAIN_W     = 16,
  parameter int INT_W      = 48,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 16,
  parameter int DIV        = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] desired_pos,
  input  logic signed [DATA_W-1:0] actual_pos,
  input  logic signed [GAIN_W-1:0] kp,
  input  logic signed [GAIN_W-1:0] ki,
  input  logic signed [GAIN_W-1:0] kd,
  input  logic        [OUT_W-2:0]  out_limit,
  input  logic        [INT_W-2:0]  int_limit,
  input  logic        [DATA_W-2:0] deadband,
  input  logic                     integ_clear,
  output logic signed [OUT_W-1:0]  control_signal,
  output logic                     out_valid,
  output logic                     saturated
);

  localparam int CNT_W = $clog2(DIV);
  localparam int P_W   = GAIN_W + DATA_W;
  localparam int D_W   = GAIN_W + DATA_W + 1;
  localparam int I_W   = GAIN_W + INT_W;
  localparam int SUM_W = GAIN_W + INT_W + 2;

  logic [CNT_W-1:0]         count;
  logic                     tick;
  logic                     v1, v2, v3;
  logic signed [DATA_W-1:0] err;
  logic signed [DATA_W:0]   d_in;
  logic [DATA_W-1:0]        err_mag;
  logic signed [INT_W-1:0]  integral, integ_next;
  logic signed [INT_W:0]    integ_sum, lim_i, neg_lim_i;
  logic signed [P_W-1:0]    p_mul, p_s2;
  logic signed [D_W-1:0]    d_mul, d_s2;
  logic signed [I_W-1:0]    i_mul, i_s2;
  logic signed [SUM_W-1:0]  sum, sum_s3, lim_o, neg_lim_o;
  logic                     sat_hi, sat_lo;

  assign tick = enable && (count == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              count <= '0;
    else if (!enable || tick)  count <= '0;
    else                       count <= count + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      err <= '0;
    end else begin
      v1 <= tick;
      if (tick) err <= desired_pos - actual_pos;
    end
  end

`ifdef PID_DERIV_ON_MEAS_EN
  logic signed [DATA_W-1:0] act_s1, prev_actual;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_s1      <= '0;
      prev_actual <= '0;
    end else if (tick) begin
      act_s1      <= actual_pos;
      prev_actual <= act_s1;
    end
  end

  assign d_in = $signed({prev_actual[DATA_W-1], prev_actual}) - $signed({act_s1[DATA_W-1], act_s1});
`else
  logic signed [DATA_W-1:0] prev_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   prev_err <= '0;
    else if (tick)  prev_err <= err;
  end

  assign d_in = $signed({err[DATA_W-1], err}) - $signed({prev_err[DATA_W-1], prev_err});
`endif

  // Most-negative error maps to 2^(DATA_W-1) as an unsigned magnitude, which is still correct.
  assign err_mag   = err[DATA_W-1] ? $unsigned(-err) : $unsigned(err);
  assign integ_sum = $signed({integral[INT_W-1], integral})
                   + $signed({{(INT_W + 1 - DATA_W){err[DATA_W-1]}}, err});
  assign lim_i     = $signed({2'b00, int_limit});
  assign neg_lim_i = -lim_i;

  always_comb begin
    integ_next = integral;
    if (integ_clear)
      integ_next = '0;
    else if (err_mag <= {1'b0, deadband})
      integ_next = integral;
    else if ((sat_hi && !err[DATA_W-1] && (err != '0)) || (sat_lo && err[DATA_W-1]))
      integ_next = integral;
    else if (integ_sum > lim_i)
      integ_next = lim_i[INT_W-1:0];
    else if (integ_sum < neg_lim_i)
      integ_next = neg_lim_i[INT_W-1:0];
    else
      integ_next = integ_sum[INT_W-1:0];
  end

  assign p_mul = $signed({{DATA_W{kp[GAIN_W-1]}}, kp}) * $signed({{GAIN_W{err[DATA_W-1]}}, err});
  assign d_mul = $signed({{(DATA_W + 1){kd[GAIN_W-1]}}, kd}) * $signed({{GAIN_W{d_in[DATA_W]}}, d_in});
  assign i_mul = $signed({{INT_W{ki[GAIN_W-1]}}, ki}) * $signed({{GAIN_W{integ_next[INT_W-1]}}, integ_next});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2       <= 1'b0;
      p_s2     <= '0;
      d_s2     <= '0;
      i_s2     <= '0;
      integral <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p_s2 <= p_mul;
        d_s2 <= d_mul;
        i_s2 <= i_mul;
      end
      if (integ_clear) integral <= '0;
      else if (v1)     integral <= integ_next;
    end
  end

  assign sum = $signed({{(SUM_W - P_W){p_s2[P_W-1]}}, p_s2})
             + $signed({{(SUM_W - I_W){i_s2[I_W-1]}}, i_s2})
             + $signed({{(SUM_W - D_W){d_s2[D_W-1]}}, d_s2});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3     <= 1'b0;
      sum_s3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) sum_s3 <= sum >>> FRAC_SHIFT;
    end
  end

  // out_limit is OUT_W-1 bits wide, so it never exceeds the largest positive output.
  assign lim_o     = $signed({{(SUM_W - OUT_W + 1){1'b0}}, out_limit});
  assign neg_lim_o = -lim_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control_signal <= '0;
      sat_hi         <= 1'b0;
      sat_lo         <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        sat_hi <= (sum_s3 > lim_o);
        sat_lo <= (sum_s3 < neg_lim_o);
        if (sum_s3 > lim_o)           control_signal <= lim_o[OUT_W-1:0];
        else if (sum_s3 < neg_lim_o)  control_signal <= neg_lim_o[OUT_W-1:0];
        else                          control_signal <= sum_s3[OUT_W-1:0];
      end
    end
  end

  assign saturated = sat_hi | sat_lo;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Self-checking bench for pid_ctrl_param: directed vector table, timing sequences, randomized model check.
module tb_pid_ctrl_param;
  localparam int DIV = 10;
  localparam longint BIG = 64'd1 << 40;

  logic               clk = 1'b0;
  logic               reset_n, enable, integ_clear;
  logic signed [31:0] desired_pos, actual_pos;
  logic signed [15:0] kp, ki, kd;
  logic [14:0]        out_limit;
  logic [46:0]        int_limit;
  logic [30:0]        deadband;
  logic signed [15:0] control_signal;
  logic               out_valid, saturated;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pid_ctrl_param #(.DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .desired_pos(desired_pos), .actual_pos(actual_pos),
    .kp(kp), .ki(ki), .kd(kd),
    .out_limit(out_limit), .int_limit(int_limit), .deadband(deadband),
    .integ_clear(integ_clear),
    .control_signal(control_signal), .out_valid(out_valid), .saturated(saturated)
  );

  typedef struct {
    int     des, act, kp, ki, kd, ol;
    longint il;
    int     db;
    bit     clr;
    int     exp_out;
    bit     exp_sat;
  } vec_t;

  vec_t tbl[17];

  // Reference model state, one update per sample.
  longint m_integ, m_prev_err, m_prev_act;
  bit     m_sat_hi, m_sat_lo;

  task automatic model_reset();
    m_integ = 0; m_prev_err = 0; m_prev_act = 0; m_sat_hi = 0; m_sat_lo = 0;
  endtask

  task automatic model_step(input vec_t v, output longint y, output bit sat);
    longint e, mag, acc, dt, s;
    e   = longint'(v.des) - longint'(v.act);
    mag = (e < 0) ? -e : e;
    if (v.clr) m_integ = 0;
    else if (mag <= longint'(v.db)) begin end
    else if ((m_sat_hi && e > 0) || (m_sat_lo && e < 0)) begin end
    else begin
      acc = m_integ + e;
      if (acc > v.il) acc = v.il;
      else if (acc < -v.il) acc = -v.il;
      m_integ = acc;
    end
`ifdef PID_DERIV_ON_MEAS_EN
    dt = m_prev_act - longint'(v.act);
`else
    dt = e - m_prev_err;
`endif
    s = longint'(v.kp) * e + longint'(v.ki) * m_integ + longint'(v.kd) * dt;
    y = s >>> 16;
    m_sat_hi = (y > longint'(v.ol));
    m_sat_lo = (y < -longint'(v.ol));
    if (m_sat_hi) y = v.ol;
    if (m_sat_lo) y = -v.ol;
    sat = m_sat_hi | m_sat_lo;
    m_prev_err = e;
    m_prev_act = v.act;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    desired_pos = v.des;
    actual_pos  = v.act;
    kp          = v.kp[15:0];
    ki          = v.ki[15:0];
    kd          = v.kd[15:0];
    out_limit   = v.ol[14:0];
    int_limit   = v.il[46:0];
    deadband    = v.db[30:0];
    integ_clear = v.clr;
  endtask

  task automatic wait_valid(output int n);
    bit ok;
    ok = 0;
    n  = 0;
    while (!ok && n < 40) begin
      @(posedge clk); #1;
      n++;
      ok = out_valid;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=no strobe required=strobe within 40 clk");
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int     n, strobes;
    longint held, y;
    bit     s;
    vec_t   v;

    //          des      act  kp     ki     kd     ol     il    db    clr out     sat
    tbl[0]  = '{400,     0,   16384, 0,     0,     32767, BIG,  0,    0,  100,    0};
    tbl[1]  = '{100000,  0,   32767, 0,     0,     10000, BIG,  0,    0,  10000,  1};
    tbl[2]  = '{-100000, 0,   32767, 0,     0,     10000, BIG,  0,    0,  -10000, 1};
    tbl[3]  = '{500,     0,   0,     16384, 0,     32767, 3000, 1000, 1,  0,      0};
    tbl[4]  = '{500,     0,   0,     16384, 0,     32767, 3000, 1000, 0,  0,      0};
    tbl[5]  = '{2000,    0,   0,     16384, 0,     32767, 3000, 1000, 0,  500,    0};
    tbl[6]  = '{2000,    0,   0,     16384, 0,     32767, 3000, 1000, 0,  750,    0};
    tbl[7]  = '{2000,    0,   0,     16384, 0,     32767, 3000, 1000, 0,  750,    0};
    tbl[8]  = '{-1,      0,   1,     0,     0,     32767, 3000, 1000, 0,  -1,     0};
    tbl[9]  = '{0,       -400,0,     0,     16384, 32767, 3000, 1000, 0,  100,    0};
    tbl[10] = '{0,       0,   0,     0,     16384, 32767, 3000, 1000, 0,  -100,   0};
    tbl[11] = '{0,       0,   0,     0,     0,     32767, BIG,  1000, 1,  0,      0};
    tbl[12] = '{100000,  0,   32767, 16384, 0,     10000, BIG,  0,    0,  10000,  1};
    tbl[13] = '{100000,  0,   32767, 16384, 0,     10000, BIG,  0,    0,  10000,  1};
    tbl[14] = '{100000,  0,   0,     16384, 0,     32767, BIG,  0,    0,  25000,  0};
    tbl[15] = '{-100000, 0,   0,     16384, 0,     32767, BIG,  0,    0,  0,      0};
    tbl[16] = '{-100000, 0,   0,     16384, 0,     32767, BIG,  0,    0,  -25000, 0};

    enable  = 1'b1;
    reset_n = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", control_signal, 0);
    check("reset_valid", out_valid, 0);
    check("reset_sat", saturated, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k]);
      wait_valid(n);
      check($sformatf("vec%0d_out", k), control_signal, tbl[k].exp_out);
      check($sformatf("vec%0d_sat", k), saturated, tbl[k].exp_sat);
    end

    // Strobe is one cycle wide and repeats every DIV clocks.
    @(posedge clk); #1;
    check("strobe_width", out_valid, 0);
    wait_valid(n);
    check("strobe_period", n + 1, DIV);

    // A one-cycle integ_clear away from the sample edge still empties the integrator.
    v = '{4000, 0, 0, 16384, 0, 32767, BIG, 0, 0, 0, 0};
    drive(v);
    wait_valid(n);
    @(posedge clk); #1 integ_clear = 1'b1;
    @(posedge clk); #1 integ_clear = 1'b0;
    wait_valid(n);
    check("clear_pulse_out", control_signal, 1000);

    // Disabled controller produces no strobes and holds its output.
    held = control_signal;
    enable = 1'b0;
    strobes = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) strobes++;
    end
    check("disabled_strobes", strobes, 0);
    check("disabled_hold", control_signal, held);
    enable = 1'b1;
    wait_valid(n);
    check("reenable_out", control_signal, 2000);

    // Disable right after a tick: the in-flight sample still completes.
    repeat (7) @(posedge clk);
    #1 enable = 1'b0;
    wait_valid(n);
    check("inflight_latency", n, 3);
    check("inflight_out", control_signal, 3000);
    strobes = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) strobes++;
    end
    check("after_inflight_strobes", strobes, 0);
    enable = 1'b1;
    wait_valid(n);
    check("resume_out", control_signal, 4000);

    // Reset one cycle after a tick aborts the sample.
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_out", control_signal, 0);
    check("midreset_sat", saturated, 0);
    strobes = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) strobes++;
    end
    check("midreset_strobes", strobes, 0);
    reset_n = 1'b1;
    wait_valid(n);
    check("first_valid_latency", n, DIV + 3);
    check("first_after_reset_out", control_signal, 1000);

    // Randomized samples against the reference model.
    reset_dut();
    for (int r = 0; r < 40; r++) begin
      v.des = int'($urandom_range(0, 2097152)) - 1048576;
      v.act = int'($urandom_range(0, 2097152)) - 1048576;
      if ($urandom_range(0, 1) == 0) begin
        v.kp = int'($urandom_range(0, 65535)) - 32768;
        v.ki = int'($urandom_range(0, 65535)) - 32768;
        v.kd = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        v.kp = int'($urandom_range(0, 4000)) - 2000;
        v.ki = int'($urandom_range(0, 4000)) - 2000;
        v.kd = int'($urandom_range(0, 4000)) - 2000;
      end
      v.ol  = int'($urandom_range(0, 32767));
      v.il  = longint'($urandom_range(0, 1 << 30));
      v.db  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 500000)) : 0;
      v.clr = ($urandom_range(0, 7) == 0);
      model_step(v, y, s);
      drive(v);
      wait_valid(n);
      check($sformatf("rand%0d_out", r), control_signal, y);
      check($sformatf("rand%0d_sat", r), saturated, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
